// File: rtl/counter_reader_pkg.sv
// counter_reader shared types: FSM encoding and default sizing.
// Imported by the interface, the wait counter and the top.
package counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int NUM_CNT_DEF = 5;
    localparam int DATA_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 4;
    localparam int IDX_W       = 3;

    function automatic int wait_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/counter_reader_if.sv
// Request/response link between counter_reader and the FIFO pop counters.
// master = reader side, slave = counter side.
interface counter_reader_if
    import counter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic             req;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic [DATA_W-1:0] data_out;

    modport master (
        output req,
        output idx,
        input  valid,
        input  data_out
    );

    modport slave (
        input  req,
        input  idx,
        output valid,
        output data_out
    );
endinterface

// File: rtl/counter_reader_timeout_cnt.sv
// Loadable wait counter; expire marks the TIMEOUT-th cycle after a request.
module reader_timeout_cnt
    import counter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int W       = wait_w(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && cnt != W'(TIMEOUT)) begin
            cnt <= cnt + W'(1);
        end
    end

    // cnt counts completed wait cycles; this cycle is elapsed number cnt+1
    assign expire = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/counter_reader.sv
// Sweeps all counters, shadows the replies, commits them atomically.
// Optional COUNTER_READER_SUM_EN adds a committed running total output.
module counter_reader
    import counter_pkg::*;
#(
    parameter int NUM_CNT = NUM_CNT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        idle_in,
    counter_reader_if.master            bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err_timeout,
    output logic                        err_abort,
`ifdef COUNTER_READER_SUM_EN
    output logic [DATA_W+2:0]           total,
`endif
    output logic [NUM_CNT*DATA_W-1:0]   counts
);
    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow [NUM_CNT];

    logic expire;
    logic active;
    logic abort;
    logic last;
    logic kick;
    logic capture;
    logic timed_out;
    logic commit;

    assign active    = (state == ST_REQ) || (state == ST_WAIT) ||
                       (state == ST_NEXT);
    assign abort     = active && !idle_in;
    assign last      = (idx == IDX_W'(NUM_CNT - 1));
    assign kick      = (state == ST_IDLE) && start && idle_in;
    assign capture   = (state == ST_WAIT) && idle_in && bus.valid;
    assign timed_out = (state == ST_WAIT) && idle_in && !bus.valid &&
                       expire;
    assign commit    = (state == ST_NEXT) && idle_in && last;

    reader_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_REQ),
        .en     (state == ST_WAIT),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bus.req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (kick) state_nx = ST_REQ;
            end
            ST_REQ: begin
                bus.req  = 1'b1;
                busy     = 1'b1;
                state_nx = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (bus.valid || expire) begin
                    state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                busy = 1'b1;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (last) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_REQ;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.idx = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
            counts      <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (kick) begin
                idx         <= '0;
                err_timeout <= 1'b0;
                err_abort   <= 1'b0;
                for (int i = 0; i < NUM_CNT; i++) begin
                    shadow[i] <= '0;
                end
            end
            if (capture) begin
                shadow[idx] <= bus.data_out;
            end
            if (timed_out) begin
                shadow[idx] <= '0;
                err_timeout <= 1'b1;
            end
            if (abort) begin
                idx       <= '0;
                err_abort <= 1'b1;
            end
            if (state == ST_NEXT && idle_in) begin
                idx <= last ? '0 : idx + IDX_W'(1);
            end
            // snapshot lands with the NEXT->DONE edge so it is valid with done
            if (commit) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    counts[i*DATA_W +: DATA_W] <= shadow[i];
                end
            end
        end
    end

`ifdef COUNTER_READER_SUM_EN
    logic [DATA_W+2:0] sum_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_sh <= '0;
            total  <= '0;
        end else begin
            if (kick) begin
                sum_sh <= '0;
            end else if (capture) begin
                sum_sh <= sum_sh + (DATA_W+3)'(bus.data_out);
            end
            if (commit) begin
                total <= sum_sh;
            end
        end
    end
`endif

endmodule

// File: doc/counter_reader.md
Name: counter_reader

Overview:
- Downstream/control neighbour of the FIFO pop counters.
- When the system reports IDLE and software pulses start, it walks idx 0..NUM_CNT-1 and issues one req per index.
- Captures each returned data_out into shadow registers, then commits all counts atomically and raises done.
- Provides the counts snapshot to the checker/status logic.

Parameters:
- NUM_CNT, 5, number of counters read (idx range 0..NUM_CNT-1; max 8).
- DATA_W, 5, width of each counter value.
- TIMEOUT, 4, cycles to wait for valid after req before declaring a timeout (1..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse requesting a full read sweep
- idle_in  in  1  system IDLE; sweep allowed only while high
- valid  in  1  counter response strobe
- data_out  in  DATA_W  counter value, qualified by valid
- req  out  1  read request to counters, one-cycle pulse per index
- idx  out  3  counter index for current request
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on successful commit
- err_timeout  out  1  sticky; some index timed out in last sweep
- err_abort  out  1  sticky; last sweep aborted by idle_in falling
- counts  out  NUM_CNT*DATA_W  committed snapshot; counter i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset values:
  - req=0, idx=0, busy=0, done=0, err_timeout=0, err_abort=0.
  - counts=0; shadow registers=0; FSM=ST_IDLE.
- ST_IDLE:
  - start=1 with idle_in=1: clear both err flags and the shadow registers, then go to ST_REQ with idx=0 and busy=1.
  - start=1 with idle_in=0: ignored.
- ST_REQ:
  - req=1 for exactly this one cycle with the current idx.
  - Next state ST_WAIT; wait counter loads 0.
- ST_WAIT:
  - valid=1: capture data_out into shadow[idx] and go to ST_NEXT. Valid may arrive 1..TIMEOUT cycles after req; counters nominally answer at 1.
  - Wait counter reaches TIMEOUT without valid: shadow[idx]=0, set err_timeout, go to ST_NEXT.
- ST_NEXT:
  - idx==NUM_CNT-1: go to ST_DONE.
  - Otherwise increment idx and go to ST_REQ.
  - Nominal sweep: 3 cycles per index, so 15 cycles for 5 counters, plus one ST_DONE cycle.
- ST_DONE:
  - Copy all shadows into counts.
  - done=1 for one cycle, busy=0, idx=0, then return to ST_IDLE.
- Abort:
  - idle_in=0 in ST_REQ, ST_WAIT or ST_NEXT sets err_abort and returns to ST_IDLE next cycle with busy=0 and idx=0.
  - counts is left unchanged and done is not pulsed.
  - The abort takes priority over a simultaneous valid.
- Other inputs:
  - valid outside ST_WAIT is ignored.
  - start while busy is ignored.
- reset=1 in any state forces reset values on the next edge.
- Wait counter width is clog2(TIMEOUT+1); idx never exceeds NUM_CNT-1.

Optional Feature:
- Macro: COUNTER_READER_SUM_EN.
- When defined:
  - Adds output total, width DATA_W+3, equal to the unsigned sum of all committed counts.
  - Updated in the same cycle counts commits; reset value 0.
  - Computed by accumulating into a shadow sum during capture; timed-out entries contribute 0.
- When undefined: no total port and no adder logic.

Decomposition:
- Shared package counter_pkg:
  - FSM state encoding (ST_IDLE, ST_REQ, ST_WAIT, ST_NEXT, ST_DONE).
  - Default NUM_CNT/DATA_W constants.
  - IDX_W=3.
- One natural sub-module, reader_timeout_cnt:
  - Loadable wait counter with a terminal flag at TIMEOUT.
  - Instantiated once.
- Shadow register array and commit logic stay in the top level.

Test Plan:
- Reset held 3 cycles, then released:
  - All outputs 0, FSM idle.
  - start with idle_in=0 produces no req.
- idle_in=1 and start, with a counter model answering valid one cycle after each req with data 3,1,4,1,5:
  - req pulses at idx 0..4.
  - done pulses 16 cycles after start.
  - counts = {5,1,4,1,3} (MSB slice = idx4); busy low after done.
- Model omits valid for idx 2:
  - After 4 wait cycles, shadow[2]=0 and err_timeout=1.
  - Sweep continues; counts = {5,1,0,1,3}; done pulses.
- idle_in dropped during the ST_WAIT of idx 3:
  - err_abort=1, no done.
  - counts keeps the prior snapshot; next start clears err_abort.
- start pulsed again mid-sweep, plus a stray valid in ST_IDLE:
  - No restart, no capture.
  - reset asserted mid-sweep returns all outputs to 0 on the next edge.
- With COUNTER_READER_SUM_EN defined, data 3,1,4,1,5:
  - total=14 in the same cycle as done.
  - Repeat with data 31 for all five: total=155.
